// File: rtl/bus_mem_peripheral_if.sv
// 8088 local-bus control/address group shared between a bus master and a memory/IO slave.
// Data stays a separate inout port so the tri-state net is resolved on a plain wire.
interface bus_mem_peripheral_if #(
    parameter int ADDR_W = 20
);
    logic              ALE;
    logic              IOM;
    logic [ADDR_W-1:0] Address;
    logic              RD;
    logic              WR;
    logic              READY;

    modport master (
        output ALE,
        output IOM,
        output Address,
        output RD,
        output WR,
        input  READY
    );

    modport slave (
        input  ALE,
        input  IOM,
        input  Address,
        input  RD,
        input  WR,
        output READY
    );
endinterface

// File: rtl/bus_mem_peripheral.sv
// Memory/IO slave on the 8088 local bus: ALE address latch, window decode, register-array storage.
// Read data appears the cycle after the RD edge plus WAIT_STATES; READY is held low for WAIT_STATES cycles.
module bus_mem_peripheral #(
    parameter int          ADDR_W      = 20,
    parameter int          DATA_W      = 8,
    parameter int          DEPTH       = 256,
    parameter int unsigned BASE        = 0,
    parameter bit          IS_IO       = 1'b0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bus_mem_peripheral_if.slave   bus,
    inout  wire  [DATA_W-1:0]     Data
);
    localparam int                OFF_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_V   = ADDR_W'(BASE);
    localparam bit                NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]        CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr;
    logic                iom;
    logic [3:0]          cnt;
    logic [3:0]          cnt_d;
    logic                is_write;
    logic                is_write_d;
    logic                latch;
    logic                mem_we;
    logic                sel;
    logic                rd_req;
    logic                wr_req;
    logic [OFF_W-1:0]    offset;
    logic [DATA_W-1:0]   rd_dat;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign sel    = (addr[ADDR_W-1:OFF_W] == BASE_V[ADDR_W-1:OFF_W]) && (iom == IS_IO);
    assign offset = addr[OFF_W-1:0];
    assign rd_req = sel && !bus.RD && bus.WR;
    assign wr_req = sel && bus.RD && !bus.WR;
    assign rd_dat = mem[offset];

    assign bus.READY = (state != ST_WAIT);
    assign Data      = (state == ST_DRIVE) ? rd_dat : {DATA_W{1'bz}};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            addr     <= '0;
            iom      <= 1'b0;
            cnt      <= 4'd0;
            is_write <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            is_write <= is_write_d;
            if (latch) begin
                addr <= bus.Address;
                iom  <= bus.IOM;
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive a bus reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[offset] <= Data;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        is_write_d = is_write;
        latch      = 1'b0;
        mem_we     = 1'b0;

        case (state)
            ST_IDLE: begin
                latch = bus.ALE;
                if (rd_req) begin
                    is_write_d = 1'b0;
                    if (NO_WAIT) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (wr_req) begin
                    is_write_d = 1'b1;
                    if (NO_WAIT) begin
                        mem_we  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.RD && bus.WR) begin
                    state_d = ST_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else if (is_write) begin
                    mem_we  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (bus.RD) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (bus.WR) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset edge must never commit a pending write.
        if (RESET) begin
            mem_we = 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_mem_peripheral.sv
// Directed bench: three peripheral instances (zero-wait memory, 3-wait IO, 4-wait memory) on one stimulus set.
// An idle Data net is probed by driving 0 from the bench; any competing slave drive corrupts the readback.
module tb_bus_mem_peripheral;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ale = 1'b0;
    logic        iom = 1'b0;
    logic [19:0] addr = '0;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        oe = 1'b1;
    logic [7:0]  dat = 8'h00;
    int          sel_dut = 0;
    int          total = 0;
    int          bad = 0;

    wire  [7:0]  d0;
    wire  [7:0]  d1;
    wire  [7:0]  d2;
    logic [7:0]  cur_data;
    logic        cur_ready;

    always #5 clk = ~clk;

    bus_mem_peripheral_if #(.ADDR_W(20)) bus0 ();
    bus_mem_peripheral_if #(.ADDR_W(20)) bus1 ();
    bus_mem_peripheral_if #(.ADDR_W(20)) bus2 ();

    assign bus0.ALE = ale && (sel_dut == 0);
    assign bus1.ALE = ale && (sel_dut == 1);
    assign bus2.ALE = ale && (sel_dut == 2);
    assign bus0.RD  = (sel_dut == 0) ? rd : 1'b1;
    assign bus1.RD  = (sel_dut == 1) ? rd : 1'b1;
    assign bus2.RD  = (sel_dut == 2) ? rd : 1'b1;
    assign bus0.WR  = (sel_dut == 0) ? wr : 1'b1;
    assign bus1.WR  = (sel_dut == 1) ? wr : 1'b1;
    assign bus2.WR  = (sel_dut == 2) ? wr : 1'b1;
    assign bus0.IOM = iom;
    assign bus1.IOM = iom;
    assign bus2.IOM = iom;
    assign bus0.Address = addr;
    assign bus1.Address = addr;
    assign bus2.Address = addr;

    assign d0 = (oe && sel_dut == 0) ? dat : 8'bz;
    assign d1 = (oe && sel_dut == 1) ? dat : 8'bz;
    assign d2 = (oe && sel_dut == 2) ? dat : 8'bz;

    assign cur_data  = (sel_dut == 0) ? d0 : (sel_dut == 1) ? d1 : d2;
    assign cur_ready = (sel_dut == 0) ? bus0.READY : (sel_dut == 1) ? bus1.READY : bus2.READY;

    bus_mem_peripheral #(.ADDR_W(20), .DATA_W(8), .DEPTH(256), .BASE(32'h00400), .IS_IO(1'b0), .WAIT_STATES(0))
        dut0 (.CLK(clk), .RESET(rst), .bus(bus0), .Data(d0));
    bus_mem_peripheral #(.ADDR_W(20), .DATA_W(8), .DEPTH(256), .BASE(32'h00400), .IS_IO(1'b1), .WAIT_STATES(3))
        dut1 (.CLK(clk), .RESET(rst), .bus(bus1), .Data(d1));
    bus_mem_peripheral #(.ADDR_W(20), .DATA_W(8), .DEPTH(256), .BASE(32'h00400), .IS_IO(1'b0), .WAIT_STATES(4))
        dut2 (.CLK(clk), .RESET(rst), .bus(bus2), .Data(d2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_latch(input logic [19:0] a, input logic io);
        addr = a;
        iom  = io;
        ale  = 1'b1;
        tick();
        ale  = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic io, input logic [7:0] v, output int waits);
        bus_latch(a, io);
        oe  = 1'b1;
        dat = v;
        wr  = 1'b0;
        waits = 0;
        tick();
        while (!cur_ready && waits < 40) begin
            waits++;
            tick();
        end
        wr = 1'b1;
        tick();
        dat = 8'h00;
    endtask

    // probe=1 keeps the bench driving 0 so a non-responding slave reads back as 0.
    task automatic do_read(input logic [19:0] a, input logic io, input bit probe,
                           output logic [7:0] val, output int waits, output logic [7:0] rel);
        bus_latch(a, io);
        oe  = probe;
        dat = 8'h00;
        rd  = 1'b0;
        waits = 0;
        tick();
        while (!cur_ready && waits < 40) begin
            waits++;
            tick();
        end
        val = cur_data;
        rd  = 1'b1;
        tick();
        oe  = 1'b1;
        #1;
        rel = cur_data;
    endtask

    initial begin
        int         w;
        logic [7:0] v;
        logic [7:0] r;

        // Reset held with a selected address presented and RD low
        sel_dut = 0;
        addr = 20'h00412;
        ale  = 1'b1;
        rd   = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(cur_ready), 32'h1);
        chk("rst_data", 32'(cur_data), 32'h0);
        ale = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_ready", 32'(cur_ready), 32'h1);
        chk("post_rst_data", 32'(cur_data), 32'h0);
        rd = 1'b1;
        tick();

        // Zero-wait write then read-back
        do_write(20'h00412, 1'b0, 8'hA5, w);
        chk("wr0_waits", 32'(w), 32'd0);
        do_read(20'h00412, 1'b0, 1'b0, v, w, r);
        chk("rd0_waits", 32'(w), 32'd0);
        chk("rd0_data", 32'(v), 32'hA5);
        chk("rd0_release", 32'(r), 32'h0);

        // Window edges
        do_write(20'h004FF, 1'b0, 8'h11, w);
        do_write(20'h00400, 1'b0, 8'h22, w);
        do_read(20'h004FF, 1'b0, 1'b0, v, w, r);
        chk("wrap_ff", 32'(v), 32'h11);
        do_read(20'h00400, 1'b0, 1'b0, v, w, r);
        chk("wrap_00", 32'(v), 32'h22);

        // Outside the window: never acknowledged, storage untouched
        do_write(20'h00500, 1'b0, 8'h77, w);
        chk("miss_wr_waits", 32'(w), 32'd0);
        do_read(20'h00500, 1'b0, 1'b1, v, w, r);
        chk("miss_rd_data", 32'(v), 32'h0);
        chk("miss_rd_waits", 32'(w), 32'd0);
        do_read(20'h00400, 1'b0, 1'b0, v, w, r);
        chk("miss_no_alias", 32'(v), 32'h22);

        // Long WR strobe: only the value at the first WR-low edge is stored
        bus_latch(20'h00420, 1'b0);
        oe  = 1'b1;
        dat = 8'h3C;
        wr  = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            dat = 8'hC0 + 8'(i);
            tick();
        end
        wr  = 1'b1;
        tick();
        do_read(20'h00420, 1'b0, 1'b0, v, w, r);
        chk("long_wr", 32'(v), 32'h3C);

        // RD and WR low together: no drive, no write
        bus_latch(20'h00412, 1'b0);
        oe  = 1'b1;
        dat = 8'h00;
        rd  = 1'b0;
        wr  = 1'b0;
        tick();
        tick();
        chk("illegal_ready", 32'(cur_ready), 32'h1);
        chk("illegal_data", 32'(cur_data), 32'h0);
        rd = 1'b1;
        wr = 1'b1;
        tick();
        do_read(20'h00412, 1'b0, 1'b0, v, w, r);
        chk("illegal_nowrite", 32'(v), 32'hA5);

        // IO-space instance with three wait states
        sel_dut = 1;
        do_write(20'h00407, 1'b1, 8'h4E, w);
        chk("io_wr_waits", 32'(w), 32'd3);
        do_read(20'h00407, 1'b1, 1'b0, v, w, r);
        chk("io_rd_waits", 32'(w), 32'd3);
        chk("io_rd_data", 32'(v), 32'h4E);
        chk("io_rd_release", 32'(r), 32'h0);
        do_write(20'h00407, 1'b0, 8'h99, w);
        chk("io_memcyc_wr_waits", 32'(w), 32'd0);
        do_read(20'h00407, 1'b0, 1'b1, v, w, r);
        chk("io_memcyc_rd_data", 32'(v), 32'h0);
        chk("io_memcyc_rd_waits", 32'(w), 32'd0);
        do_read(20'h00407, 1'b1, 1'b0, v, w, r);
        chk("io_unchanged", 32'(v), 32'h4E);

        // Four wait states: early RD release aborts, reset during write WAIT drops the write
        sel_dut = 2;
        do_write(20'h00410, 1'b0, 8'h66, w);
        chk("ws4_wr_waits", 32'(w), 32'd4);
        bus_latch(20'h00410, 1'b0);
        oe = 1'b0;
        rd = 1'b0;
        tick();
        tick();
        chk("abort_in_wait", 32'(cur_ready), 32'h0);
        rd = 1'b1;
        tick();
        oe  = 1'b1;
        dat = 8'h00;
        #1;
        chk("abort_ready", 32'(cur_ready), 32'h1);
        chk("abort_data", 32'(cur_data), 32'h0);
        tick();
        chk("abort_idle", 32'(cur_ready), 32'h1);

        bus_latch(20'h00410, 1'b0);
        oe  = 1'b1;
        dat = 8'h99;
        wr  = 1'b0;
        repeat (4) tick();
        chk("rstwait_ready", 32'(cur_ready), 32'h0);
        rst = 1'b1;
        tick();
        chk("rstwait_ready_rst", 32'(cur_ready), 32'h1);
        rst = 1'b0;
        wr  = 1'b1;
        tick();
        do_read(20'h00410, 1'b0, 1'b0, v, w, r);
        chk("rstwait_nowrite", 32'(v), 32'h66);
        chk("ws4_rd_waits", 32'(w), 32'd4);

        // Storage on the first instance survived the reset
        sel_dut = 0;
        do_read(20'h004FF, 1'b0, 1'b0, v, w, r);
        chk("mem_survives_rst", 32'(v), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
